hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: Decode/Execute hazard signals between the core pipeline
// (master) and the hazard controller (slave). Register indices are 5 bits.
// There is no valid/ready handshake: every input is sampled each cycle as
// the current Decode/Execute contents, md_done is a single-cycle pulse, and
// every output is a level that applies to the current cycle only.
interface hazard_ctrl_if;
   logic [4:0] rs1_d;
   logic [4:0] rs2_d;
   logic       rs1_used_d;
   logic       rs2_used_d;
   logic [4:0] rd_d;
   logic       regwrite_d;
   logic       memread_d;
   logic       pc_src_e;
   logic       md_start_e;
   logic       md_done;
   logic [1:0] fwd_a_e;
   logic [1:0] fwd_b_e;
   logic       stall_f;
   logic       stall_d;
   logic       flush_d;
   logic       flush_e;
   logic       md_busy;

   modport master (
      output rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, regwrite_d, memread_d,
      output pc_src_e, md_start_e, md_done,
      input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, md_busy
   );

   modport slave (
      input  rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, regwrite_d, memread_d,
      input  pc_src_e, md_start_e, md_done,
      output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, md_busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use / RAW stalls, branch flushes and
// a two-state mul/div freeze FSM for the 5-stage core. A shadow pipeline of
// E/M/W destination state is kept locally.
// Build option: define HAZARD_FORWARD_EN to enable Execute forwarding with a
// load-use stall; without it forwarding is off and any RAW dependency on
// E/M/W stalls Decode instead.
module hazard_ctrl (
   input  logic clk,
   input  logic rst_n,
   hazard_ctrl_if.slave hz
);
   typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

   md_state_t  state;
   logic       md_busy_q;

   logic [4:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       regwrite_e, regwrite_m, regwrite_w;
`ifdef HAZARD_FORWARD_EN
   logic       memread_e;
`endif

   logic       md_stall;
   logic       hazard_d;
   logic       stall_c, flush_d_c, flush_e_c;
   logic [1:0] fwd_a_c, fwd_b_c;

   assign md_stall = ((state == IDLE) && hz.md_start_e) ||
                     ((state == MD_BUSY) && !hz.md_done);

`ifdef HAZARD_FORWARD_EN
   // M result is younger than W, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rdm, input logic rwm,
                                          input logic [4:0] rdw, input logic rww);
      if (rwm && (rdm != 5'd0) && (rdm == rs))      return 2'b10;
      else if (rww && (rdw != 5'd0) && (rdw == rs)) return 2'b01;
      else                                          return 2'b00;
   endfunction

   assign fwd_a_c  = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
   assign fwd_b_c  = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
   assign hazard_d = memread_e && (rd_e != 5'd0) &&
                     ((hz.rs1_used_d && (hz.rs1_d == rd_e)) ||
                      (hz.rs2_used_d && (hz.rs2_d == rd_e)));
`else
   // A used, nonzero Decode source that any in-flight writer targets.
   function automatic logic raw_hit(input logic [4:0] rs, input logic used,
                                    input logic [4:0] rde, input logic rwe,
                                    input logic [4:0] rdm, input logic rwm,
                                    input logic [4:0] rdw, input logic rww);
      return used && (rs != 5'd0) &&
             ((rwe && (rde == rs)) || (rwm && (rdm == rs)) || (rww && (rdw == rs)));
   endfunction

   assign fwd_a_c  = 2'b00;
   assign fwd_b_c  = 2'b00;
   assign hazard_d = raw_hit(hz.rs1_d, hz.rs1_used_d, rd_e, regwrite_e,
                             rd_m, regwrite_m, rd_w, regwrite_w) ||
                     raw_hit(hz.rs2_d, hz.rs2_used_d, rd_e, regwrite_e,
                             rd_m, regwrite_m, rd_w, regwrite_w);
`endif

   // Prioritise branch flush over the MD freeze over the data-hazard stall.
   always_comb begin
      stall_c   = 1'b0;
      flush_d_c = 1'b0;
      flush_e_c = 1'b0;
      if (hz.pc_src_e) begin
         flush_d_c = 1'b1;
         flush_e_c = 1'b1;
      end else if (md_stall) begin
         stall_c = 1'b1;
      end else if (hazard_d) begin
         stall_c   = 1'b1;
         flush_e_c = 1'b1;
      end
   end

   // Outputs are forced quiet while reset is held, regardless of inputs.
   assign hz.fwd_a_e = rst_n ? fwd_a_c : 2'b00;
   assign hz.fwd_b_e = rst_n ? fwd_b_c : 2'b00;
   assign hz.stall_f = rst_n & stall_c;
   assign hz.stall_d = rst_n & stall_c;
   assign hz.flush_d = rst_n & flush_d_c;
   assign hz.flush_e = rst_n & flush_e_c;
   assign hz.md_busy = md_busy_q;

   // MD freeze FSM; md_busy_q is a registered copy of (state == MD_BUSY).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         md_busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hz.md_start_e) begin
                  state     <= MD_BUSY;
                  md_busy_q <= 1'b1;
               end
            end
            MD_BUSY: begin
               if (hz.md_done) begin
                  state     <= IDLE;
                  md_busy_q <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               md_busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Shadow E/M/W: E bubbles on flush, holds during the MD freeze; M bubbles
   // while frozen so the held E instruction is not duplicated downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_e      <= 5'd0;
         rs2_e      <= 5'd0;
         rd_e       <= 5'd0;
         regwrite_e <= 1'b0;
`ifdef HAZARD_FORWARD_EN
         memread_e  <= 1'b0;
`endif
         rd_m       <= 5'd0;
         regwrite_m <= 1'b0;
         rd_w       <= 5'd0;
         regwrite_w <= 1'b0;
      end else begin
         if (flush_e_c) begin
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            rd_e       <= 5'd0;
            regwrite_e <= 1'b0;
`ifdef HAZARD_FORWARD_EN
            memread_e  <= 1'b0;
`endif
         end else if (!md_stall) begin
            rs1_e      <= hz.rs1_d;
            rs2_e      <= hz.rs2_d;
            rd_e       <= hz.rd_d;
            regwrite_e <= hz.regwrite_d;
`ifdef HAZARD_FORWARD_EN
            memread_e  <= hz.memread_d;
`endif
         end
         if (md_stall) begin
            rd_m       <= 5'd0;
            regwrite_m <= 1'b0;
         end else begin
            rd_m       <= rd_e;
            regwrite_m <= regwrite_e;
         end
         rd_w       <= rd_m;
         regwrite_w <= regwrite_m;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: cycle-by-cycle vector table for hazard_ctrl plus a
// hand-written reset-during-MD sequence. Expected outputs are packed as
// {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, md_busy}.
module tb_hazard_ctrl;
   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
      logic       pc;
      logic       ms;
      logic       md;
      logic [8:0] exp;
   } vec_t;

   localparam logic [8:0] E_NONE  = 9'b00_00_0000_0;
   localparam logic [8:0] E_RAW   = 9'b00_00_1101_0;
   localparam logic [8:0] E_MD    = 9'b00_00_1100_0;
   localparam logic [8:0] E_BSTL  = 9'b00_00_1100_1;
   localparam logic [8:0] E_BUSY  = 9'b00_00_0000_1;
   localparam logic [8:0] E_FLUSH = 9'b00_00_0011_0;

   logic clk;
   logic rst_n;
   hazard_ctrl_if hz();

   hazard_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   vec_t       vecs[$];
   logic [8:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit rw, input bit mr, input bit pc,
                               input bit ms, input bit md, input logic [8:0] e);
      vec_t v;
      v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
      v.rd  = 5'(rd);  v.rw  = rw; v.mr = mr; v.pc = pc; v.ms = ms; v.md = md;
      v.exp = e;
      vecs.push_back(v);
   endfunction

   function automatic vec_t mk(input int rs1, input int rs2, input int rd,
                               input bit pc, input bit ms, input logic [8:0] e);
      vec_t v;
      v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'b1; v.u2 = 1'b1;
      v.rd  = 5'(rd);  v.rw  = 1'b1; v.mr = 1'b0; v.pc = pc; v.ms = ms; v.md = 1'b0;
      v.exp = e;
      return v;
   endfunction

   // driver: apply one Decode/Execute vector and queue its expectation
   task automatic drive(input vec_t v);
      hz.rs1_d      = v.rs1;
      hz.rs2_d      = v.rs2;
      hz.rs1_used_d = v.u1;
      hz.rs2_used_d = v.u2;
      hz.rd_d       = v.rd;
      hz.regwrite_d = v.rw;
      hz.memread_d  = v.mr;
      hz.pc_src_e   = v.pc;
      hz.md_start_e = v.ms;
      hz.md_done    = v.md;
      exp_q.push_back(v.exp);
   endtask

   // scoreboard: compare at the falling edge against the oldest expectation
   task automatic check(input string name);
      logic [8:0] act;
      logic [8:0] e;
      @(negedge clk);
      act = {hz.fwd_a_e, hz.fwd_b_e, hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e, hz.md_busy};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got %b but no expectation queued", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b (fa fb sf sd fd fe busy)", name, act, e);
         end
      end
   endtask

   task automatic nop(input logic [8:0] e);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
   endtask

   initial begin
      vec_t idle_v;
      idle_v = mk(0, 0, 0, 1'b1, 1'b0, E_NONE);
      idle_v.u1 = 1'b0; idle_v.u2 = 1'b0; idle_v.rw = 1'b0;

`ifdef HAZARD_FORWARD_EN
      add(1, 2, 1, 1, 5, 1, 0, 0, 0, 0, E_NONE);        // add x5
      add(5, 6, 1, 1, 8, 1, 0, 0, 0, 0, E_NONE);        // sub reads x5
      nop(9'b10_00_0000_0);                             // sub in E: from M
      add(1, 2, 1, 1, 5, 1, 0, 0, 0, 0, E_NONE);
      nop(E_NONE);                                      // one-instruction gap
      add(5, 9, 1, 1, 11, 1, 0, 0, 0, 0, E_NONE);
      nop(9'b01_00_0000_0);                             // from W
      add(1, 2, 1, 1, 9, 1, 0, 0, 0, 0, E_NONE);
      add(3, 4, 1, 1, 9, 1, 0, 0, 0, 0, E_NONE);
      add(9, 9, 1, 1, 13, 1, 0, 0, 0, 0, E_NONE);
      nop(9'b10_10_0000_0);                             // M beats W, both operands
      add(1, 2, 1, 1, 0, 1, 0, 0, 0, 0, E_NONE);        // writes x0
      add(0, 0, 1, 1, 14, 1, 0, 0, 0, 0, E_NONE);       // reads x0
      nop(E_NONE);                                      // x0 in M: no forward
      nop(E_NONE);                                      // x0 in W: no forward
      add(1, 0, 1, 0, 7, 1, 1, 0, 0, 0, E_NONE);        // lw x7
      add(3, 7, 1, 1, 15, 1, 0, 0, 0, 0, E_RAW);        // load-use bubble
      add(3, 7, 1, 1, 15, 1, 0, 0, 0, 0, E_NONE);
      nop(9'b00_01_0000_0);                             // rs2 from W
      add(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, E_NONE);        // lw x0
      add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_NONE);        // no load-use on x0
      add(1, 0, 1, 0, 7, 1, 1, 0, 0, 0, E_NONE);        // lw x7
      add(3, 7, 1, 1, 15, 1, 0, 1, 0, 0, E_FLUSH);      // branch beats load-use
      nop(E_NONE);
      add(12, 2, 1, 1, 12, 1, 0, 0, 0, 0, E_NONE);      // mul x12
      add(12, 0, 1, 0, 10, 1, 0, 0, 1, 0, E_MD);        // md_start_e
      for (int i = 0; i < 3; i++) add(12, 0, 1, 0, 10, 1, 0, 0, 0, 0, E_BSTL);
      add(12, 0, 1, 0, 10, 1, 0, 0, 0, 1, E_BUSY);      // md_done: stall drops
      nop(9'b10_00_0000_0);                             // held mul now in M
`else
      add(1, 2, 1, 1, 5, 1, 0, 0, 0, 0, E_NONE);        // add x5
      for (int i = 0; i < 3; i++) add(5, 6, 1, 1, 8, 1, 0, 0, 0, 0, E_RAW);
      add(5, 6, 1, 1, 8, 1, 0, 0, 0, 0, E_NONE);        // after 3 stalls
      nop(E_NONE);
      add(3, 0, 1, 0, 0, 1, 0, 0, 0, 0, E_NONE);        // writes x0
      add(0, 0, 1, 0, 9, 1, 0, 0, 0, 0, E_NONE);        // reads x0: no stall
      add(4, 9, 1, 0, 0, 0, 0, 0, 0, 0, E_NONE);        // rs2 unused
      add(4, 9, 1, 1, 0, 0, 0, 0, 0, 0, E_RAW);         // x9 in M
      add(4, 9, 1, 1, 0, 0, 0, 0, 0, 0, E_RAW);         // x9 in W
      add(4, 9, 1, 1, 0, 0, 0, 0, 0, 0, E_NONE);
      add(1, 0, 1, 0, 7, 1, 1, 0, 0, 0, E_NONE);        // lw x7
      add(3, 7, 1, 1, 15, 1, 0, 1, 0, 0, E_FLUSH);      // branch beats RAW
      add(12, 2, 1, 1, 12, 1, 0, 0, 0, 0, E_NONE);      // mul x12
      add(12, 0, 1, 0, 10, 1, 0, 0, 1, 0, E_MD);        // md_start_e hides RAW
      for (int i = 0; i < 3; i++) add(12, 0, 1, 0, 10, 1, 0, 0, 0, 0, E_BSTL);
      add(12, 0, 1, 0, 10, 1, 0, 0, 0, 1, 9'b00_00_1101_1); // md_done, held mul in E
      add(12, 0, 1, 0, 10, 1, 0, 0, 0, 0, E_RAW);       // mul in M
      add(12, 0, 1, 0, 10, 1, 0, 0, 0, 0, E_RAW);       // mul in W
      add(12, 0, 1, 0, 10, 1, 0, 0, 0, 0, E_NONE);
      nop(E_NONE);
`endif

      // reset with a live branch request: outputs must stay quiet
      rst_n = 1'b0;
      drive(idle_v);
      check("reset_hold");
      @(posedge clk);
      #1;
      hz.pc_src_e = 1'b0;
      rst_n = 1'b1;

      // vector table
      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         drive(vecs[i]);
         check($sformatf("vec%0d", i));
      end

      // reset in the 2nd MD_BUSY cycle
      @(posedge clk); #1; drive(mk(1, 2, 20, 1'b0, 1'b0, E_NONE));   check("rst_seq_a");
      @(posedge clk); #1; drive(mk(20, 20, 21, 1'b0, 1'b1, E_MD));   check("rst_seq_start");
      @(posedge clk); #1; drive(mk(20, 20, 21, 1'b0, 1'b0, E_BSTL)); check("rst_seq_busy1");
      @(posedge clk); #1; drive(mk(20, 20, 21, 1'b1, 1'b0, E_NONE));
      #1 rst_n = 1'b0;
      check("rst_seq_async");
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(mk(20, 20, 21, 1'b0, 1'b0, E_NONE));                    check("rst_seq_release");
      @(posedge clk); #1; drive(idle_v);
      hz.pc_src_e = 1'b0;
      exp_q[exp_q.size() - 1] = E_NONE;
      check("rst_seq_empty");

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d queued expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
